// File: rtl/conv1d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_pkg
// Purpose  : FSM state encoding and width helpers for the 1D convolution core
// Revision : 1.0 - initial release
// ============================================================================
package conv1d_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_FETCH = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_WRITE = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Exact accumulation: product width plus one bit per possible term count
    function automatic int acc_width(input int wx, input int wy, input int ax, input int ay);
        return wx + wy + max_int(ax, ay);
    endfunction

    // Output index n reaches sizeX+sizeY-2, which needs one bit beyond the wider size
    function automatic int idx_width(input int ax, input int ay);
        return max_int(ax, ay) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv1d_mac.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_mac
// Purpose  : Registered unsigned multiply-accumulate with clear/enable and a
//            wrap or saturate (CONV_SATURATE_EN) output stage
// Revision : 1.0 - initial release
// ============================================================================
module conv1d_mac
    import conv1d_pkg::*;
#(
    parameter int DATA_WIDTH_X = 8,
    parameter int DATA_WIDTH_Y = 8,
    parameter int DATA_WIDTH_Z = 16,
    parameter int ACC_W        = 21
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic [DATA_WIDTH_X-1:0] a_i,
    input  logic [DATA_WIDTH_Y-1:0] b_i,
    output logic [DATA_WIDTH_Z-1:0] res_o
);

    localparam int PROD_W = DATA_WIDTH_X + DATA_WIDTH_Y;

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [PROD_W-1:0] w_prod;

    assign w_prod = {{DATA_WIDTH_Y{1'b0}}, a_i} * {{DATA_WIDTH_X{1'b0}}, b_i};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(w_prod);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    generate
        if (ACC_W > DATA_WIDTH_Z) begin : g_narrow_out
`ifdef CONV_SATURATE_EN
            assign res_o = (|acc_q[ACC_W-1:DATA_WIDTH_Z]) ? '1 : acc_q[DATA_WIDTH_Z-1:0];
`else
            assign res_o = acc_q[DATA_WIDTH_Z-1:0];
`endif
        end else begin : g_wide_out
            assign res_o = DATA_WIDTH_Z'(acc_q);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/conv1d_param_core.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_param_core
// Purpose  : Parametrised 1D convolution z[n] = sum_k x[k]*y[n-k] over
//            external sync-read RAMs; CONV_SATURATE_EN selects saturating output
// Revision : 1.0 - initial release
// ============================================================================
module conv1d_param_core #(
    parameter int DATA_WIDTH_X = 8,
    parameter int DATA_WIDTH_Y = 8,
    parameter int DATA_WIDTH_Z = 16,
    parameter int ADDR_WIDTH_X = 5,
    parameter int ADDR_WIDTH_Y = 5,
    parameter int ADDR_WIDTH_Z = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [ADDR_WIDTH_X-1:0] sizeX,
    input  logic [ADDR_WIDTH_Y-1:0] sizeY,
    output logic [ADDR_WIDTH_X-1:0] memX_addr,
    input  logic [DATA_WIDTH_X-1:0] dataX,
    output logic [ADDR_WIDTH_Y-1:0] memY_addr,
    input  logic [DATA_WIDTH_Y-1:0] dataY,
    output logic [DATA_WIDTH_Z-1:0] dataZ,
    output logic [ADDR_WIDTH_Z-1:0] memZ_addr,
    output logic                    writeZ,
    output logic                    busy,
    output logic                    done
);
    import conv1d_pkg::*;

    localparam int ACC_W = acc_width(DATA_WIDTH_X, DATA_WIDTH_Y, ADDR_WIDTH_X, ADDR_WIDTH_Y);
    localparam int N_W   = idx_width(ADDR_WIDTH_X, ADDR_WIDTH_Y);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH_X-1:0] sx_q, sx_d;
    logic [ADDR_WIDTH_Y-1:0] sy_q, sy_d;
    logic [N_W-1:0]          n_q, n_d;
    logic [N_W-1:0]          nlast_q, nlast_d;
    logic [ADDR_WIDTH_X-1:0] kmax_q, kmax_d;
    logic [ADDR_WIDTH_X-1:0] addrx_q, addrx_d;
    logic [ADDR_WIDTH_Y-1:0] addry_q, addry_d;
    logic                    first_q, first_d;
    logic                    writeZ_q, writeZ_d;
    logic [DATA_WIDTH_Z-1:0] dataZ_q, dataZ_d;
    logic [ADDR_WIDTH_Z-1:0] memZ_addr_q, memZ_addr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    w_mac_clr;
    logic                    w_mac_en;
    logic [DATA_WIDTH_Z-1:0] w_mac_res;
    logic [N_W-1:0]          w_sx_n, w_sy_n, w_kmin_n, w_kmax_n, w_ny_n;

    // Term window for output n: kmin = max(0, n-sizeY+1), kmax = min(n, sizeX-1)
    assign w_sx_n   = N_W'(sx_q);
    assign w_sy_n   = N_W'(sy_q);
    assign w_kmin_n = (n_q >= w_sy_n) ? (n_q - w_sy_n + N_W'(1)) : '0;
    assign w_kmax_n = (n_q < (w_sx_n - N_W'(1))) ? n_q : (w_sx_n - N_W'(1));
    assign w_ny_n   = n_q - w_kmin_n;

    always_comb begin
        state_d     = state_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        n_d         = n_q;
        nlast_d     = nlast_q;
        kmax_d      = kmax_q;
        addrx_d     = addrx_q;
        addry_d     = addry_q;
        first_d     = first_q;
        writeZ_d    = 1'b0;
        dataZ_d     = '0;
        memZ_addr_d = '0;
        busy_d      = (state_q == ST_SETUP) || (state_q == ST_FETCH) ||
                      (state_q == ST_DRAIN) || (state_q == ST_WRITE);
        done_d      = (state_q == ST_DONE);
        w_mac_clr   = 1'b0;
        w_mac_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sx_d    = sizeX;
                    sy_d    = sizeY;
                    n_d     = '0;
                    nlast_d = N_W'(sizeX) + N_W'(sizeY) - N_W'(2);
                    state_d = ((sizeX == '0) || (sizeY == '0)) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_mac_clr = 1'b1;
                addrx_d   = ADDR_WIDTH_X'(w_kmin_n);
                addry_d   = ADDR_WIDTH_Y'(w_ny_n);
                kmax_d    = ADDR_WIDTH_X'(w_kmax_n);
                first_d   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_FETCH: begin
                // RAM data lags the address by one cycle, so the first fetch has nothing to add
                w_mac_en = !first_q;
                first_d  = 1'b0;
                if (addrx_q == kmax_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    addrx_d = addrx_q + ADDR_WIDTH_X'(1);
                    addry_d = addry_q - ADDR_WIDTH_Y'(1);
                end
            end
            ST_DRAIN: begin
                w_mac_en = 1'b1;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                writeZ_d    = 1'b1;
                dataZ_d     = w_mac_res;
                memZ_addr_d = ADDR_WIDTH_Z'(n_q);
                if (n_q == nlast_q) begin
                    state_d = ST_DONE;
                end else begin
                    n_d     = n_q + N_W'(1);
                    state_d = ST_SETUP;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            sx_q        <= '0;
            sy_q        <= '0;
            n_q         <= '0;
            nlast_q     <= '0;
            kmax_q      <= '0;
            addrx_q     <= '0;
            addry_q     <= '0;
            first_q     <= 1'b0;
            writeZ_q    <= 1'b0;
            dataZ_q     <= '0;
            memZ_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            n_q         <= n_d;
            nlast_q     <= nlast_d;
            kmax_q      <= kmax_d;
            addrx_q     <= addrx_d;
            addry_q     <= addry_d;
            first_q     <= first_d;
            writeZ_q    <= writeZ_d;
            dataZ_q     <= dataZ_d;
            memZ_addr_q <= memZ_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    conv1d_mac #(
        .DATA_WIDTH_X (DATA_WIDTH_X),
        .DATA_WIDTH_Y (DATA_WIDTH_Y),
        .DATA_WIDTH_Z (DATA_WIDTH_Z),
        .ACC_W        (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (w_mac_clr),
        .en_i  (w_mac_en),
        .a_i   (dataX),
        .b_i   (dataY),
        .res_o (w_mac_res)
    );

    assign memX_addr = addrx_q;
    assign memY_addr = addry_q;
    assign writeZ    = writeZ_q;
    assign dataZ     = dataZ_q;
    assign memZ_addr = memZ_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv1d_param_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv1d_param_core
// Purpose  : Directed self-checking bench for conv1d_param_core (8-bit result)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv1d_param_core;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [4:0] sizeX = '0;
    logic [4:0] sizeY = '0;
    logic [4:0] memX_addr, memY_addr;
    logic [7:0] dataX, dataY;
    logic [7:0] dataZ;
    logic [5:0] memZ_addr;
    logic       writeZ, busy, done;

    always #5 clk = ~clk;

    conv1d_param_core #(
        .DATA_WIDTH_X (8),
        .DATA_WIDTH_Y (8),
        .DATA_WIDTH_Z (8),
        .ADDR_WIDTH_X (5),
        .ADDR_WIDTH_Y (5),
        .ADDR_WIDTH_Z (6)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .sizeX     (sizeX),
        .sizeY     (sizeY),
        .memX_addr (memX_addr),
        .dataX     (dataX),
        .memY_addr (memY_addr),
        .dataY     (dataY),
        .dataZ     (dataZ),
        .memZ_addr (memZ_addr),
        .writeZ    (writeZ),
        .busy      (busy),
        .done      (done)
    );

    logic [7:0] memx [32];
    logic [7:0] memy [32];

    always @(posedge clk) begin
        dataX <= memx[memX_addr];
        dataY <= memy[memY_addr];
    end

    int         wcnt = 0;
    int         proto_err = 0;
    int         busy_cnt = 0;
    logic [7:0] zlog [256];
    logic [5:0] alog [256];
    logic [7:0] zexp [64];

    always @(posedge clk) begin
        #1;
        if (writeZ) begin
            if (wcnt < 256) begin
                zlog[wcnt] = dataZ;
                alog[wcnt] = memZ_addr;
            end
            wcnt++;
            if (!busy) proto_err++;
        end else if (dataZ != '0 || memZ_addr != '0) begin
            proto_err++;
        end
        if (busy) busy_cnt++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Raise start, then count edges after the start-sampling edge until done is seen
    task automatic do_run(input int sx, input int sy, output int cyc);
        @(negedge clk);
        sizeX = 5'(sx);
        sizeY = 5'(sy);
        start = 1'b1;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        while (!done && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic check_writes(input string tag, input int base, input int nexp);
        chk_eq({tag, "_wcnt"}, 32'(wcnt - base), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            chk_eq($sformatf("%s_z%0d", tag, i), {24'd0, zlog[base + i]}, {24'd0, zexp[i]});
            chk_eq($sformatf("%s_a%0d", tag, i), {26'd0, alog[base + i]}, 32'(i));
        end
    endtask

    task automatic load_t1();
        for (int i = 0; i < 32; i++) begin
            memx[i] = '0;
            memy[i] = '0;
        end
        memx[0] = 8'd1; memx[1] = 8'd2; memx[2] = 8'd3;
        for (int i = 0; i < 4; i++) memy[i] = 8'd1;
        zexp[0] = 8'd1; zexp[1] = 8'd3; zexp[2] = 8'd6;
        zexp[3] = 8'd6; zexp[4] = 8'd5; zexp[5] = 8'd3;
    endtask

    initial begin
        int base, cyc, bc, g;

        load_t1();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_outputs", {5'd0, busy, done, writeZ, dataZ, memZ_addr, memX_addr, memY_addr}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Scenario 1, then start held high through done
        base = wcnt;
        do_run(3, 4, cyc);
        chk_eq("t1_cycles", 32'(cyc), 32'd31);
        repeat (10) @(negedge clk);
        chk_eq("t5_hold_wcnt", 32'(wcnt - base), 32'd6);
        chk_eq("t5_hold_done", {31'd0, done}, 32'd1);
        check_writes("t1", base, 6);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk_eq("t5_done_drop", {31'd0, done}, 32'd0);

        // Retrigger: identical second run
        base = wcnt;
        do_run(3, 4, cyc);
        chk_eq("t5_cycles", 32'(cyc), 32'd31);
        check_writes("t5", base, 6);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Single-tap kernel: z[n] = 2n
        for (int i = 0; i < 32; i++) begin
            memx[i] = '0;
            memy[i] = 8'(i);
        end
        memx[0] = 8'd2;
        for (int i = 0; i < 10; i++) zexp[i] = 8'(2 * i);
        base = wcnt;
        do_run(1, 10, cyc);
        chk_eq("t2_cycles", 32'(cyc), 32'd41);
        check_writes("t2", base, 10);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Empty signal: no writes, no busy
        base = wcnt;
        bc   = busy_cnt;
        do_run(3, 0, cyc);
        chk_eq("t3_cycles", 32'(cyc), 32'd1);
        chk_eq("t3_wcnt", 32'(wcnt - base), 32'd0);
        chk_eq("t3_busy", 32'(busy_cnt - bc), 32'd0);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Overflow of the 8-bit result
        memx[0] = 8'd255; memx[1] = 8'd255;
        memy[0] = 8'd255; memy[1] = 8'd255;
`ifdef CONV_SATURATE_EN
        zexp[0] = 8'hFF; zexp[1] = 8'hFF; zexp[2] = 8'hFF;
`else
        zexp[0] = 8'h01; zexp[1] = 8'h02; zexp[2] = 8'h01;
`endif
        base = wcnt;
        do_run(2, 2, cyc);
        chk_eq("t4_cycles", 32'(cyc), 32'd14);
        check_writes("t4", base, 3);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during output n=2 of scenario 1
        load_t1();
        base = wcnt;
        @(negedge clk);
        sizeX = 5'd3;
        sizeY = 5'd4;
        start = 1'b1;
        g = 0;
        while ((wcnt - base) < 2 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk_eq("t6_reach", 32'(wcnt - base), 32'd2);
        @(negedge clk);
        rstn  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk_eq("t6_rst_outputs", {5'd0, busy, done, writeZ, dataZ, memZ_addr, memX_addr, memY_addr}, 32'd0);
        repeat (20) @(negedge clk);
        chk_eq("t6_no_writes", 32'(wcnt - base), 32'd2);

        base = wcnt;
        do_run(3, 4, cyc);
        chk_eq("t6_cycles", 32'(cyc), 32'd31);
        check_writes("t6", base, 6);
        start = 1'b0;
        repeat (3) @(negedge clk);

        chk_eq("proto_idle_zero", 32'(proto_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
